scale_shifter: RTL
==================

# scale_shifter

Parametrised, pipelined shift-and-scale stage for the 64-point FFT datapath. It widens a DATA_WIDTH sample to OUT_WIDTH and applies a runtime left shift or arithmetic right shift, with optional round-half-up and saturation. It sits between butterfly stages for block-floating-point scaling and replaces fixed-amount, fixed-direction shifting with a valid/ready stream stage that supports backpressure.

## Interface
- DATA_WIDTH, 16, input sample width
- OUT_WIDTH, 32, output width; must be ≥ DATA_WIDTH+1
- SHIFT_WIDTH, 5, width of shift amount (max shift 2^SHIFT_WIDTH−1)
- SIGNED, 1, 1 = two's-complement sign-extend; 0 = zero-extend, right shift is logical
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept the beat
- in_data  in  DATA_WIDTH  sample
- in_shamt  in  SHIFT_WIDTH  shift amount
- in_dir  in  1  0 = left, 1 = right
- in_round  in  1  round-half-up on right shift
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_data  out  OUT_WIDTH  scaled result
- out_ovf  out  1  this beat saturated
- ovf_sticky  out  1  overflow seen since last clear
- ovf_clr  in  1  clear ovf_sticky

## Operation
- Extend in_data to OUT_WIDTH+2^SHIFT_WIDTH bits (sign or zero per SIGNED).
- Left: value·2^shamt. If the result exceeds the OUT_WIDTH range, saturate to max/min (0x7FF…F / 0x800…0 when signed; all-ones when unsigned) and set out_ovf.
- Right: if in_round and shamt>0, add 2^(shamt−1) first, then shift arithmetically. This path never overflows.
- shamt=0: pass-through extension. in_round is ignored.
- Sticky: set on the cycle after out_valid && out_ready && out_ovf. ovf_clr clears it. If set and clear happen together, set wins.
- Stage 1 registers the wide shifted value and the overflow flag. Stage 2 registers the saturated/truncated out_data and out_ovf.
- Each stage is an elastic slice:
  - stage 2 loads when empty or when out_ready is high;
  - stage 1 advances when stage 2 can load;
  - in_ready = !s1_valid || s1_advance.

## Timing
- Latency is 2 cycles from an accepted input beat to out_valid, assuming no backpressure.
- Throughput is 1 beat per cycle.
- While out_valid && !out_ready, out_data and out_ovf stay stable. No beat is lost or reordered.
- With both stages full and out_ready low, in_ready is 0.
- in_ready depends combinationally on out_ready. There is no other combinational input→output path.
- Reset: s1_valid=0, out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0. Beats in flight are discarded immediately, without waiting for a clock edge.
- First acceptance after reset deassertion is on the next rising edge.

## Configuration
- SCALE_SHIFTER_SAT_EN defined: saturation and overflow detection as described above.
- Not defined: left shift wraps modulo 2^OUT_WIDTH (truncation). out_ovf and ovf_sticky are tied to 0, and the overflow detection logic is removed. Latency is unchanged.

## Structure
- Shared package scale_shifter_pkg holds:
  - constants DIR_LEFT=0 and DIR_RIGHT=1;
  - the width function WIDE_W = OUT_WIDTH+2^SHIFT_WIDTH;
  - saturation limit constants derived from OUT_WIDTH/SIGNED.
- Sub-module scale_shifter_slice: a generic valid/ready pipeline register with a parametrised payload width. It is instantiated twice, once for stage 1 and once for stage 2.

## Test plan
All cases use the default parameters.
- Left shift: in_data=0x1234, shamt=8, dir=0 → out_data=0x00123400 two cycles later, out_ovf=0.
- Right shift: in_data=0xFFF3 (−13), shamt=2, dir=1.
  - round=0 → 0xFFFFFFFC;
  - round=1 → 0xFFFFFFFD.
- Saturation:
  - 0x4000, left 20 → 0x7FFFFFFF, out_ovf=1, ovf_sticky=1 after the handshake;
  - 0x8000, left 16 → 0x80000000, ovf=0;
  - 0x8000, left 17 → 0x80000000, ovf=1.
- Backpressure: 3 back-to-back beats with out_ready held low for 5 cycles.
  - in_ready drops after 2 accepted beats;
  - out_data stays stable;
  - after release, all 3 beats appear in order.
- Reset mid-stream: assert rst with 2 beats in flight.
  - out_valid=0 and ovf_sticky=0 without waiting for a clock edge;
  - no stale beat appears after release.
- ovf_clr asserted in the same cycle as an overflowed beat handshake → ovf_sticky stays 1. A subsequent lone ovf_clr → 0.

Source files
------------

// File: rtl/scale_shifter_pkg.sv
// Shared constants and helpers for the scale_shifter block-floating-point stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: shift direction encodings, the internal wide-datapath width
// function, and saturation limit builders parametrised by output width and
// signedness.

package scale_shifter_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Upper bound on OUT_WIDTH that the saturation-limit helpers can describe.
  localparam int SAT_VEC_W = 256;

  // Internal width wide enough to hold any sample shifted left by the
  // largest shift amount without losing bits.
  function automatic int wide_w(input int out_w, input int shift_w);
    return out_w + (1 << shift_w);
  endfunction

  // Largest representable OUT_WIDTH value, right-aligned in a SAT_VEC_W vector.
  function automatic logic [SAT_VEC_W-1:0] sat_max(input int out_w, input bit is_signed);
    logic [SAT_VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_VEC_W; i++) begin
      if (i < out_w - (is_signed ? 1 : 0)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Smallest representable OUT_WIDTH value (only the sign bit set when signed).
  function automatic logic [SAT_VEC_W-1:0] sat_min(input int out_w, input bit is_signed);
    logic [SAT_VEC_W-1:0] v;
    v = '0;
    if (is_signed) v[out_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scale_shifter_slice.sv
// Generic elastic valid/ready pipeline register with a W-bit payload.
// Latency: 1 cycle.
// Backpressure: loads when empty or when out_ready is high; holds payload stable otherwise.
//
// Ports: clk/rst (async active-high), in_valid/in_ready/in_data upstream,
// out_valid/out_ready/out_data downstream. in_ready is combinational on out_ready.

module scale_shifter_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/scale_shifter.sv
// Widen a sample to OUT_WIDTH and apply a runtime left shift or (rounded) arithmetic right shift.
// Latency: 2 cycles from accepted input beat to out_valid; 1 beat/cycle throughput.
// Backpressure: two elastic slices; in_ready = !s1_valid || stage-2-can-load (combinational on out_ready).
//
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_shamt/in_dir/in_round input
// stream; out_valid/out_ready/out_data/out_ovf output stream; ovf_sticky with ovf_clr.
// Build option SCALE_SHIFTER_SAT_EN: defined = saturate left-shift overflow and report it;
// undefined = left shift wraps modulo 2^OUT_WIDTH, out_ovf/ovf_sticky tied low.

module scale_shifter
  import scale_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int SIGNED      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shamt,
  input  logic                   in_dir,
  input  logic                   in_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_ovf,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);

  localparam int WIDE_W = wide_w(OUT_WIDTH, SHIFT_WIDTH);

  // ---------------- stage-1 combinational datapath ----------------
  logic [WIDE_W-1:0]        ext;
  logic [WIDE_W-1:0]        left_val;
  logic [WIDE_W-1:0]        rnd_add;
  logic [WIDE_W-1:0]        rsum;
  logic signed [WIDE_W-1:0] rsum_s;
  logic [WIDE_W-1:0]        ashr_val;
  logic [WIDE_W-1:0]        lshr_val;
  logic [WIDE_W-1:0]        shifted;

  assign ext = (SIGNED != 0) ? {{(WIDE_W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data}
                             : {{(WIDE_W-DATA_WIDTH){1'b0}}, in_data};

  assign left_val = ext << in_shamt;

  // Half-LSB bias for round-half-up; a zero shift has nothing to round.
  assign rnd_add = (in_round && (in_shamt != '0))
                 ? (WIDE_W'(1) << (in_shamt - SHIFT_WIDTH'(1))) : '0;
  assign rsum    = ext + rnd_add;
  assign rsum_s  = rsum;
  // Kept as separate signed assignment so >>> stays arithmetic.
  assign ashr_val = rsum_s >>> in_shamt;
  assign lshr_val = rsum >> in_shamt;

  assign shifted = (in_dir == DIR_RIGHT) ? ((SIGNED != 0) ? ashr_val : lshr_val) : left_val;

  logic s1_valid;
  logic s2_can_load;
  logic s2_valid;

`ifdef SCALE_SHIFTER_SAT_EN
  localparam int S1_W = WIDE_W + 1;
  localparam int S2_W = OUT_WIDTH + 1;

  localparam logic [SAT_VEC_W-1:0] SAT_MAX_V = sat_max(OUT_WIDTH, SIGNED != 0);
  localparam logic [SAT_VEC_W-1:0] SAT_MIN_V = sat_min(OUT_WIDTH, SIGNED != 0);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX   = SAT_MAX_V[OUT_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0] SAT_MIN   = SAT_MIN_V[OUT_WIDTH-1:0];

  // Signed: every bit from the OUT_WIDTH sign position upward must agree.
  // Unsigned: nothing may spill above OUT_WIDTH.
  logic range_ovf;
  logic left_ovf;
  assign range_ovf = (SIGNED != 0)
                   ? !((&shifted[WIDE_W-1:OUT_WIDTH-1]) || !(|shifted[WIDE_W-1:OUT_WIDTH-1]))
                   : (|shifted[WIDE_W-1:OUT_WIDTH]);
  // A right shift of an extended DATA_WIDTH sample always fits OUT_WIDTH.
  assign left_ovf  = (in_dir == DIR_LEFT) && range_ovf;

  logic [S1_W-1:0] s1_in;
  logic [S1_W-1:0] s1_out;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_out;
  logic [OUT_WIDTH-1:0] sat_data;

  assign s1_in = {left_ovf, shifted};

  // Direction of saturation follows the sign of the wide result.
  assign sat_data = !s1_out[WIDE_W] ? s1_out[OUT_WIDTH-1:0]
                  : (((SIGNED != 0) && s1_out[WIDE_W-1]) ? SAT_MIN : SAT_MAX);
  assign s2_in    = {s1_out[WIDE_W], sat_data};

  assign out_data = s2_out[OUT_WIDTH-1:0];
  assign out_ovf  = s2_out[OUT_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  // Wrapping build: bits above OUT_WIDTH never reach the output, so stage 1
  // keeps only the low OUT_WIDTH bits of the wide result.
  localparam int S1_W = OUT_WIDTH;
  localparam int S2_W = OUT_WIDTH;

  logic [S1_W-1:0] s1_in;
  logic [S1_W-1:0] s1_out;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_out;

  assign s1_in      = shifted[OUT_WIDTH-1:0];
  assign s2_in      = s1_out;
  assign out_data   = s2_out;
  assign out_ovf    = 1'b0;
  assign ovf_sticky = 1'b0;

  logic unused_wrap;
  assign unused_wrap = &{1'b0, ovf_clr, shifted[WIDE_W-1:OUT_WIDTH]};
`endif

  scale_shifter_slice #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_can_load),
    .out_data  (s1_out)
  );

  scale_shifter_slice #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_can_load),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_valid = s2_valid;

endmodule
